thermal_encode_ctrl: RTL

- Sequencer that streams the stored input image, pixel by pixel, through the combinational thermometer encoder.
- Drives the encoder's pixel and write-enable inputs, and supplies the write address for the INPUT_WIDTH bit-plane memories that feed the first binarized layer.
- Handles 1-cycle image-RAM read latency, downstream backpressure, and start/busy/done signalling to the top-level network FSM.

---
 rtl/thermal_encode_ctrl.sv | 120 ++++++++++++
 1 files changed

// File: rtl/thermal_encode_ctrl.sv
// Streams a stored image pixel-by-pixel from image RAM into the thermometer encoder.
// Optional stall counter port is enabled with `define THERM_CTRL_PERF_EN.
module thermal_encode_ctrl #(
   parameter int NUM_PIXELS  = 784,
   parameter int ADDR_WIDTH  = 10,
   parameter int INPUT_WIDTH = 8
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   start,
   output logic                   busy,
   output logic                   done,
   output logic                   img_rd_en,
   output logic [ADDR_WIDTH-1:0]  img_rd_addr,
   input  logic [INPUT_WIDTH-1:0] img_rd_data,
   input  logic                   plane_wr_ready,
   output logic [INPUT_WIDTH-1:0] enc_pixel,
   output logic                   enc_write_en,
   output logic [ADDR_WIDTH-1:0]  plane_wr_addr
`ifdef THERM_CTRL_PERF_EN
   ,
   output logic [15:0]            stall_cycles
`endif
);

   localparam int CW = ADDR_WIDTH + 1;
   localparam logic [CW-1:0] LAST = CW'(NUM_PIXELS);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

   state_t                 state_q, state_d;
   logic [CW-1:0]          rd_cnt_q, rd_cnt_d;
   logic [CW-1:0]          wr_cnt_q, wr_cnt_d;
   logic                   rd_pend_q;
   logic [1:0]             fifo_cnt_q, fifo_cnt_d;
   logic                   fifo_wp_q, fifo_rp_q;
   logic [INPUT_WIDTH-1:0] fifo_mem_q [2];
   logic [INPUT_WIDTH-1:0] pix_hold_q;
   logic [ADDR_WIDTH-1:0]  addr_hold_q;
   logic                   push, pop, start_ok;
   logic [2:0]             inflight;

   always_comb begin
      push      = rd_pend_q;
      pop       = (fifo_cnt_q != 2'd0) && plane_wr_ready && !rst;
      inflight  = {1'b0, fifo_cnt_q} + {2'b00, rd_pend_q};
      // A read may be issued into a full window only if a slot frees this cycle.
      img_rd_en = !rst && (state_q == S_RUN) && (rd_cnt_q < LAST) &&
                  ((inflight < 3'd2) || ((inflight == 3'd2) && pop));
      img_rd_addr   = rd_cnt_q[ADDR_WIDTH-1:0];
      enc_write_en  = pop;
      enc_pixel     = pop ? fifo_mem_q[fifo_rp_q] : pix_hold_q;
      plane_wr_addr = pop ? wr_cnt_q[ADDR_WIDTH-1:0] : addr_hold_q;
      rd_cnt_d      = rd_cnt_q + CW'(img_rd_en);
      wr_cnt_d      = wr_cnt_q + CW'(pop);
      fifo_cnt_d    = fifo_cnt_q + 2'(push) - 2'(pop);
      start_ok      = (state_q == S_IDLE) && start;
      busy          = (state_q == S_RUN) || (state_q == S_DRAIN);
      done          = (state_q == S_DONE);

      state_d = state_q;
      case (state_q)
         S_IDLE:  if (start) state_d = S_RUN;
         S_RUN:   if (rd_cnt_d == LAST) state_d = S_DRAIN;
         S_DRAIN: if ((wr_cnt_d == LAST) && (fifo_cnt_d == 2'd0)) state_d = S_DONE;
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         rd_cnt_q    <= '0;
         wr_cnt_q    <= '0;
         rd_pend_q   <= 1'b0;
         fifo_cnt_q  <= 2'd0;
         fifo_wp_q   <= 1'b0;
         fifo_rp_q   <= 1'b0;
         pix_hold_q  <= '0;
         addr_hold_q <= '0;
      end else begin
         state_q   <= state_d;
         rd_pend_q <= img_rd_en;
         if (start_ok || (state_q == S_DONE)) begin
            rd_cnt_q <= '0;
            wr_cnt_q <= '0;
         end else begin
            rd_cnt_q <= rd_cnt_d;
            wr_cnt_q <= wr_cnt_d;
         end
         fifo_cnt_q <= fifo_cnt_d;
         if (push) fifo_wp_q <= ~fifo_wp_q;
         if (pop) begin
            fifo_rp_q   <= ~fifo_rp_q;
            pix_hold_q  <= fifo_mem_q[fifo_rp_q];
            addr_hold_q <= wr_cnt_q[ADDR_WIDTH-1:0];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (push) fifo_mem_q[fifo_wp_q] <= img_rd_data;
   end

`ifdef THERM_CTRL_PERF_EN
   logic [15:0] stall_q;

   always_ff @(posedge clk) begin
      if (rst || start_ok) begin
         stall_q <= '0;
      end else if (busy && (fifo_cnt_q != 2'd0) && !plane_wr_ready && (stall_q != 16'hFFFF)) begin
         stall_q <= stall_q + 16'd1;
      end
   end

   assign stall_cycles = stall_q;
`endif

endmodule
